ps2_zx_matrix: RTL and testbench

- Sequences the byte stream from the PS/2 receiver: prefix/break state machine over the set-2 scancodes.
- Maintains the ZX Spectrum 8x5 keyboard matrix from those scancodes.
- Serves the ULA's half-row reads (address lines A15..A8) with active-low column data.
- Sits between the PS/2 receiver (its key byte and valid level) and the ULA's port 0xFE read path.

---
 rtl/ps2_zx_matrix.sv | 223 ++++++++++++++++++++++
 tb/tb_ps2_zx_matrix.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_zx_matrix.sv
// PS/2 set-2 scancode sequencer driving a ZX Spectrum 8x5 keyboard matrix,
// with the ULA half-row read path (active-low rows in, active-low columns out).
module ps2_zx_matrix #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] kbd_key,
    input  logic       kbd_key_valid,
    input  logic [7:0] row_sel,
    output logic [4:0] cols,
    output logic       key_event
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned KEYS   = 40;
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned SYM_IX = 36;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic               sync1, sync2, sync3;
    logic               byte_v;
    logic [7:0]         byte_r;
    logic [CNT_W-1:0]   tmo_cnt;
    logic               tmo_hit;
    logic [KEYS-1:0]    matrix;
    logic               sym_a;
    logic               sym_b;
    logic [KEYS-1:0]    eff;
    logic               hit;
    logic [IDX_W-1:0]   idx;
    logic               is_sym_a;
    logic               is_sym_b;
    logic               do_press;
    logic               do_release;
    logic               do_clear;
    logic               is_prefix;

    // Synchronise the valid level, detect its rising edge, capture the byte
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            sync3  <= 1'b0;
            byte_v <= 1'b0;
            byte_r <= 8'h00;
        end else begin
            sync1  <= kbd_key_valid;
            sync2  <= sync1;
            sync3  <= sync2;
            byte_v <= sync2 & ~sync3;
            if (sync2 & ~sync3) begin
                byte_r <= kbd_key;
            end
        end
    end

    // Prefix timeout counter: cleared in IDLE and by every byte, saturating
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (byte_v || state == IDLE) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != {CNT_W{1'b1}}) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

    assign tmo_hit = (state != IDLE) && (tmo_cnt == TIMEOUT_CYCLES - 16'd1);

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    assign is_prefix = (byte_r == 8'hE0) || (byte_r == 8'hF0);

    // Next-state: a captured byte takes priority over a timeout
    always_comb begin
        state_nx = state;
        if (byte_v) begin
            case (state)
                IDLE: begin
                    if (byte_r == 8'hE0) begin
                        state_nx = EXT;
                    end else if (byte_r == 8'hF0) begin
                        state_nx = BRK;
                    end
                end
                EXT:     state_nx = (byte_r == 8'hF0) ? EXT_BRK : IDLE;
                BRK:     state_nx = IDLE;
                EXT_BRK: state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end else if (tmo_hit) begin
            state_nx = IDLE;
        end
    end

    // FSM outputs: matrix actions for the byte being processed
    always_comb begin
        do_press   = 1'b0;
        do_release = 1'b0;
        do_clear   = 1'b0;
        if (byte_v) begin
            case (state)
                IDLE: begin
                    if (byte_r == 8'h00 || byte_r == 8'hFF) begin
                        do_clear = 1'b1;
                    end else if (!is_prefix && byte_r != 8'hAA) begin
                        do_press = 1'b1;
                    end
                end
                BRK: begin
                    if (is_prefix) begin
                        do_clear = 1'b1;
                    end else begin
                        do_release = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Scancode to matrix index (row*5 + column); SymShift sources kept apart
    always_comb begin
        hit      = 1'b1;
        idx      = '0;
        is_sym_a = (byte_r == 8'h59);
        is_sym_b = (byte_r == 8'h14);
        case (byte_r)
            8'h12: idx = 6'd0;   8'h1A: idx = 6'd1;   8'h22: idx = 6'd2;
            8'h21: idx = 6'd3;   8'h2A: idx = 6'd4;
            8'h1C: idx = 6'd5;   8'h1B: idx = 6'd6;   8'h23: idx = 6'd7;
            8'h2B: idx = 6'd8;   8'h34: idx = 6'd9;
            8'h15: idx = 6'd10;  8'h1D: idx = 6'd11;  8'h24: idx = 6'd12;
            8'h2D: idx = 6'd13;  8'h2C: idx = 6'd14;
            8'h16: idx = 6'd15;  8'h1E: idx = 6'd16;  8'h26: idx = 6'd17;
            8'h25: idx = 6'd18;  8'h2E: idx = 6'd19;
            8'h45: idx = 6'd20;  8'h46: idx = 6'd21;  8'h3E: idx = 6'd22;
            8'h3D: idx = 6'd23;  8'h36: idx = 6'd24;
            8'h4D: idx = 6'd25;  8'h44: idx = 6'd26;  8'h43: idx = 6'd27;
            8'h3C: idx = 6'd28;  8'h35: idx = 6'd29;
            8'h5A: idx = 6'd30;  8'h4B: idx = 6'd31;  8'h42: idx = 6'd32;
            8'h3B: idx = 6'd33;  8'h33: idx = 6'd34;
            8'h29: idx = 6'd35;  8'h3A: idx = 6'd37;  8'h31: idx = 6'd38;
            8'h32: idx = 6'd39;
            default: hit = 1'b0;
        endcase
    end

    // Matrix state and key_event; only actual state changes raise an event
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            matrix    <= '0;
            sym_a     <= 1'b0;
            sym_b     <= 1'b0;
            key_event <= 1'b0;
        end else begin
            key_event <= 1'b0;
            if (do_clear) begin
                matrix    <= '0;
                sym_a     <= 1'b0;
                sym_b     <= 1'b0;
                key_event <= (|matrix) | sym_a | sym_b;
            end else if (do_press) begin
                if (hit && !matrix[idx]) begin
                    matrix[idx] <= 1'b1;
                    key_event   <= 1'b1;
                end else if (is_sym_a && !sym_a) begin
                    sym_a     <= 1'b1;
                    key_event <= 1'b1;
                end else if (is_sym_b && !sym_b) begin
                    sym_b     <= 1'b1;
                    key_event <= 1'b1;
                end
            end else if (do_release) begin
                if (hit && matrix[idx]) begin
                    matrix[idx] <= 1'b0;
                    key_event   <= 1'b1;
                end else if (is_sym_a && sym_a) begin
                    sym_a     <= 1'b0;
                    key_event <= 1'b1;
                end else if (is_sym_b && sym_b) begin
                    sym_b     <= 1'b0;
                    key_event <= 1'b1;
                end
            end
        end
    end

    // Effective matrix with the two SymShift sources merged onto one bit
    always_comb begin
        eff         = matrix;
        eff[SYM_IX] = sym_a | sym_b;
    end

    // Half-row read: OR pressed keys across all selected rows, invert
    always_comb begin
        logic [4:0] sel_or;
        sel_or = 5'b00000;
        for (int r = 0; r < 8; r++) begin
            if (!row_sel[r]) begin
                sel_or = sel_or | eff[r*5 +: 5];
            end
        end
        cols = ~sel_or;
    end

endmodule

// File: tb/tb_ps2_zx_matrix.sv
// Self-checking bench for ps2_zx_matrix against a scancode-level keyboard model.
module tb_ps2_zx_matrix;

    localparam logic [15:0] TMO = 16'd100;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] kbd_key;
    logic       kbd_key_valid;
    logic [7:0] row_sel;
    logic [4:0] cols;
    logic       key_event;

    int checks = 0;
    int errors = 0;
    int ev_cnt = 0;
    int ev_before;
    bit exp_ev;

    // reference model: per-scancode pressed flags plus prefix bookkeeping
    int   map_idx [256];
    bit   pressed [256];
    bit   m_ext;
    bit   m_brk;
    logic [7:0] tbl [40];

    ps2_zx_matrix #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .kbd_key(kbd_key), .kbd_key_valid(kbd_key_valid),
        .row_sel(row_sel), .cols(cols), .key_event(key_event)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (key_event === 1'b1) ev_cnt++;

    function automatic logic [4:0] model_cols(input logic [7:0] rs);
        logic [4:0] acc;
        acc = 5'b00000;
        for (int c = 0; c < 256; c++) begin
            if (pressed[c] && map_idx[c] >= 0 && !rs[map_idx[c] / 5])
                acc[map_idx[c] % 5] = 1'b1;
        end
        return ~acc;
    endfunction

    function automatic bit any_pressed();
        for (int c = 0; c < 256; c++) if (pressed[c]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear(output bit ev);
        ev = any_pressed();
        for (int c = 0; c < 256; c++) pressed[c] = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b, output bit ev);
        ev = 1'b0;
        if (m_ext && m_brk) begin
            m_ext = 0; m_brk = 0;
        end else if (m_ext) begin
            m_ext = 0;
            if (b == 8'hF0) begin m_ext = 1; m_brk = 1; end
        end else if (m_brk) begin
            m_brk = 0;
            if (b == 8'hE0 || b == 8'hF0) model_clear(ev);
            else if (map_idx[b] >= 0 && pressed[b]) begin pressed[b] = 0; ev = 1; end
        end else begin
            if (b == 8'hE0) m_ext = 1;
            else if (b == 8'hF0) m_brk = 1;
            else if (b == 8'h00 || b == 8'hFF) model_clear(ev);
            else if (map_idx[b] >= 0 && !pressed[b]) begin pressed[b] = 1; ev = 1; end
        end
    endtask

    task automatic model_reset();
        bit d;
        model_clear(d);
        m_ext = 0; m_brk = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ev;
        @(negedge clk);
        ev_before = ev_cnt;
        kbd_key = b;
        kbd_key_valid = 1'b1;
        repeat (6) @(posedge clk);
        #2 kbd_key_valid = 1'b0;
        repeat (4 + $urandom_range(0, 8)) @(posedge clk);
        @(negedge clk);
        model_byte(b, ev);
        exp_ev = ev;
    endtask

    task automatic test_reset();
        reset = 1'b1; kbd_key = 8'h00; kbd_key_valid = 1'b0; row_sel = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (cols !== 5'b11111) begin errors++; $display("FAIL reset_cols got=%b exp=11111", cols); end
        checks++;
        if (key_event !== 1'b0) begin errors++; $display("FAIL reset_event got=%b exp=0", key_event); end
        @(negedge clk) reset = 1'b0;
        model_reset();
    endtask

    task automatic test_latency();
        int seen;
        bit ev;
        seen = 0;
        @(negedge clk);
        ev_before = ev_cnt;
        row_sel = 8'hFD;
        kbd_key = 8'h1B; kbd_key_valid = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (key_event === 1'b1 && seen == 0) seen = n;
            if (n == 3) begin
                checks++;
                if (cols !== 5'b11111) begin errors++; $display("FAIL latency_early got=%b exp=11111", cols); end
            end
        end
        checks++;
        if (seen != 4) begin errors++; $display("FAIL latency_edge got=%0d exp=4", seen); end
        checks++;
        if (cols !== 5'b11101) begin errors++; $display("FAIL latency_cols got=%b exp=11101", cols); end
        kbd_key_valid = 1'b0;
        repeat (6) @(posedge clk);
        model_byte(8'h1B, ev);
        send_byte(8'hF0);
        send_byte(8'h1B);
        checks++;
        if (cols !== 5'b11111) begin errors++; $display("FAIL latency_release got=%b exp=11111", cols); end
    endtask

    task automatic test_press_release();
        send_byte(8'h1C);
        row_sel = 8'hFD; #1;
        checks++;
        if (cols !== 5'b11110) begin errors++; $display("FAIL press_1c got=%b exp=11110", cols); end
        checks++;
        if (ev_cnt - ev_before != 1) begin errors++; $display("FAIL press_event got=%0d exp=1", ev_cnt - ev_before); end
        send_byte(8'h1C);
        checks++;
        if (ev_cnt - ev_before != 0) begin errors++; $display("FAIL repeat_event got=%0d exp=0", ev_cnt - ev_before); end
        send_byte(8'hF0);
        send_byte(8'h1C);
        #1;
        checks++;
        if (cols !== 5'b11111) begin errors++; $display("FAIL release_1c got=%b exp=11111", cols); end
        checks++;
        if (ev_cnt - ev_before != 1) begin errors++; $display("FAIL release_event got=%0d exp=1", ev_cnt - ev_before); end
    endtask

    task automatic test_multi_row();
        send_byte(8'h12);
        send_byte(8'h1A);
        row_sel = 8'hFE; #1;
        checks++;
        if (cols !== 5'b11100) begin errors++; $display("FAIL row0 got=%b exp=11100", cols); end
        row_sel = 8'h7C; #1;
        checks++;
        if (cols !== 5'b11100) begin errors++; $display("FAIL rows_017 got=%b exp=11100", cols); end
        send_byte(8'hF0);
        send_byte(8'h12);
        row_sel = 8'hFE; #1;
        checks++;
        if (cols !== 5'b11101) begin errors++; $display("FAIL release_12 got=%b exp=11101", cols); end
        send_byte(8'hF0);
        send_byte(8'h1A);
        row_sel = 8'hFF; #1;
        checks++;
        if (cols !== 5'b11111) begin errors++; $display("FAIL none_sel got=%b exp=11111", cols); end
    endtask

    task automatic test_extended();
        send_byte(8'hE0);
        send_byte(8'h75);
        row_sel = 8'h00; #1;
        checks++;
        if (cols !== 5'b11111) begin errors++; $display("FAIL ext_ignore got=%b exp=11111", cols); end
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        #1;
        checks++;
        if (cols !== 5'b11111) begin errors++; $display("FAIL extbrk_ignore got=%b exp=11111", cols); end
        send_byte(8'h29);
        row_sel = 8'h7F; #1;
        checks++;
        if (cols !== 5'b11110) begin errors++; $display("FAIL space_after_ext got=%b exp=11110", cols); end
    endtask

    task automatic test_timeout();
        send_byte(8'hF0);
        repeat (int'(TMO) + 20) @(posedge clk);
        m_ext = 0; m_brk = 0;
        send_byte(8'h15);
        row_sel = 8'hFB; #1;
        checks++;
        if (cols !== 5'b11110) begin errors++; $display("FAIL timeout_q got=%b exp=11110", cols); end
        checks++;
        if (ev_cnt - ev_before != 1) begin errors++; $display("FAIL timeout_event got=%0d exp=1", ev_cnt - ev_before); end
    endtask

    task automatic test_symshift();
        send_byte(8'h59);
        send_byte(8'h14);
        send_byte(8'hF0);
        send_byte(8'h59);
        row_sel = 8'h7F; #1;
        checks++;
        if (cols[1] !== 1'b0) begin errors++; $display("FAIL sym_held got=%b exp=0", cols[1]); end
        checks++;
        if (cols !== model_cols(8'h7F)) begin errors++; $display("FAIL sym_row7 got=%b exp=%b", cols, model_cols(8'h7F)); end
        send_byte(8'hF0);
        send_byte(8'h14);
        #1;
        checks++;
        if (cols[1] !== 1'b1) begin errors++; $display("FAIL sym_released got=%b exp=1", cols[1]); end
        send_byte(8'h16);
        send_byte(8'h1E);
        send_byte(8'hFF);
        row_sel = 8'h00; #1;
        checks++;
        if (cols !== 5'b11111) begin errors++; $display("FAIL overrun_clear got=%b exp=11111", cols); end
        checks++;
        if (ev_cnt - ev_before != int'(exp_ev)) begin errors++; $display("FAIL overrun_event got=%0d exp=%0d", ev_cnt - ev_before, exp_ev); end
    endtask

    task automatic test_async_reset();
        send_byte(8'h16);
        send_byte(8'h2A);
        send_byte(8'hF0);
        @(posedge clk);
        #3 reset = 1'b1;
        row_sel = 8'h00;
        #1;
        checks++;
        if (cols !== 5'b11111) begin errors++; $display("FAIL async_reset got=%b exp=11111", cols); end
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        model_reset();
        send_byte(8'h1C);
        row_sel = 8'hFD; #1;
        checks++;
        if (cols !== 5'b11110) begin errors++; $display("FAIL post_reset_press got=%b exp=11110", cols); end
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic [7:0] rs;
        logic [7:0] unm [4];
        int k;
        unm[0] = 8'h75; unm[1] = 8'h0D; unm[2] = 8'h76; unm[3] = 8'h66;
        for (int i = 0; i < 250; i++) begin
            k = $urandom_range(0, 99);
            if (k < 50)      b = tbl[$urandom_range(0, 39)];
            else if (k < 55) b = 8'h14;
            else if (k < 70) b = 8'hF0;
            else if (k < 78) b = 8'hE0;
            else if (k < 88) b = unm[$urandom_range(0, 3)];
            else if (k < 92) b = 8'hAA;
            else if (k < 94) b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
            else             b = tbl[$urandom_range(0, 39)];
            send_byte(b);
            rs = 8'($urandom);
            row_sel = rs; #1;
            checks++;
            if (cols !== model_cols(rs)) begin
                errors++; $display("FAIL rand_cols byte=%h sel=%h got=%b exp=%b", b, rs, cols, model_cols(rs));
            end
            checks++;
            if (ev_cnt - ev_before != int'(exp_ev)) begin
                errors++; $display("FAIL rand_event byte=%h got=%0d exp=%0d", b, ev_cnt - ev_before, exp_ev);
            end
        end
        row_sel = 8'h00; #1;
        checks++;
        if (cols !== model_cols(8'h00)) begin errors++; $display("FAIL rand_all got=%b exp=%b", cols, model_cols(8'h00)); end
    endtask

    initial begin
        tbl = '{8'h12, 8'h1A, 8'h22, 8'h21, 8'h2A,
                8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34,
                8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,
                8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
                8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36,
                8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35,
                8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33,
                8'h29, 8'h59, 8'h3A, 8'h31, 8'h32};
        for (int c = 0; c < 256; c++) begin map_idx[c] = -1; pressed[c] = 1'b0; end
        for (int i = 0; i < 40; i++) map_idx[tbl[i]] = i;
        map_idx[8'h14] = 36;
        m_ext = 0; m_brk = 0;

        test_reset();
        test_latency();
        test_press_release();
        test_multi_row();
        test_extended();
        test_timeout();
        test_symshift();
        test_async_reset();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
